// File: rtl/adc_fsm_v1.sv
// ============================================================================
// Module   : adc_fsm_v1
// Brief    : Parametrised SAR ADC controller with averaging, channel scan,
//            DAC settling delay and comparator-timeout recovery.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adc_fsm_v1 #(
  parameter int WIDTH         = 12,
  parameter int CHANNELS      = 4,
  parameter int AVG_LOG2_MAX  = 3,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 15,
  localparam int CH_W         = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_conv,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             scan_mode,
  input  logic [1:0]       avg_log2,
  input  logic             comp_in,
  input  logic             comp_done,
  output logic             sample,
  output logic [CH_W-1:0]  mux_ch,
  output logic [WIDTH-1:0] dac_value,
  output logic             fire_comp,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             adc_done,
  output logic             busy,
  output logic             timeout_err
);

  localparam int ACC_W   = WIDTH + AVG_LOG2_MAX;
  localparam int SUB_W   = AVG_LOG2_MAX + 1;
  localparam int CNT_MAX = (SAMPLE_CYCLES > TIMEOUT)
                         ? ((SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES)
                         : ((TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_FIRE   = 3'd3,
    S_WAIT   = 3'd4,
    S_ACCUM  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   trial, trial_n;
  logic [WIDTH-1:0]   code, code_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [SUB_W-1:0]   sub_cnt, sub_n;
  logic [1:0]         avg, avg_n;
  logic               scan, scan_n;
  logic [CH_W-1:0]    chan, chan_n;
  logic [WIDTH-1:0]   res_q, res_n;
  logic [CH_W-1:0]    res_ch_q, res_ch_n;
  logic [ACC_W-1:0]   acc_sum;
  logic [SUB_W-1:0]   sub_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      trial    <= '0;
      code     <= '0;
      acc      <= '0;
      sub_cnt  <= '0;
      avg      <= '0;
      scan     <= 1'b0;
      chan     <= '0;
      res_q    <= '0;
      res_ch_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      trial    <= trial_n;
      code     <= code_n;
      acc      <= acc_n;
      sub_cnt  <= sub_n;
      avg      <= avg_n;
      scan     <= scan_n;
      chan     <= chan_n;
      res_q    <= res_n;
      res_ch_q <= res_ch_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    trial_n     = trial;
    code_n      = code;
    acc_n       = acc;
    sub_n       = sub_cnt;
    avg_n       = avg;
    scan_n      = scan;
    chan_n      = chan;
    res_n       = res_q;
    res_ch_n    = res_ch_q;
    acc_sum     = acc + ACC_W'(code);
    sub_inc     = sub_cnt + SUB_W'(1);
    sample      = 1'b0;
    fire_comp   = 1'b0;
    adc_done    = 1'b0;
    timeout_err = 1'b0;
    busy        = (state != S_IDLE);
    dac_value   = '0;
    mux_ch      = chan;
    result      = res_q;
    result_ch   = res_ch_q;

    case (state)
      S_IDLE: begin
        if (st_conv) begin
          scan_n  = scan_mode;
          chan_n  = scan_mode ? '0 : ((int'(ch_sel) >= CHANNELS) ? '0 : ch_sel);
          avg_n   = (int'(avg_log2) > AVG_LOG2_MAX) ? 2'(AVG_LOG2_MAX) : avg_log2;
          acc_n   = '0;
          sub_n   = '0;
          cnt_n   = '0;
          state_n = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        sample = 1'b1;
        if (int'(cnt) == SAMPLE_CYCLES - 1) begin
          cnt_n   = '0;
          trial_n = {1'b1, {(WIDTH-1){1'b0}}};
          code_n  = '0;
          state_n = (SETTLE_CYCLES == 0) ? S_FIRE : S_SETTLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        dac_value = code | trial;
        if (int'(cnt) == SETTLE_CYCLES - 1) begin
          cnt_n   = '0;
          state_n = S_FIRE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_FIRE: begin
        dac_value = code | trial;
        fire_comp = 1'b1;
        cnt_n     = '0;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        dac_value = code | trial;
        // A late answer on the final timeout cycle is still accepted.
        if (comp_done) begin
          code_n = comp_in ? (code | trial) : code;
          cnt_n  = '0;
          if (trial[0]) begin
            state_n = S_ACCUM;
          end else begin
            trial_n = trial >> 1;
            state_n = (SETTLE_CYCLES == 0) ? S_FIRE : S_SETTLE;
          end
        end else if (int'(cnt) == TIMEOUT - 1) begin
          timeout_err = 1'b1;
          cnt_n       = '0;
          state_n     = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_ACCUM: begin
        dac_value = code;
        acc_n     = acc_sum;
        sub_n     = sub_inc;
        cnt_n     = '0;
        if (sub_inc == (SUB_W'(1) << avg)) begin
          res_n    = WIDTH'(acc_sum >> avg);
          res_ch_n = chan;
          state_n  = S_DONE;
        end else begin
          state_n = S_SAMPLE;
        end
      end
      S_DONE: begin
        dac_value = code;
        adc_done  = 1'b1;
        if (scan && (int'(chan) < CHANNELS - 1)) begin
          chan_n  = chan + CH_W'(1);
          acc_n   = '0;
          sub_n   = '0;
          cnt_n   = '0;
          state_n = S_SAMPLE;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/adc_fsm_v1.md
# adc_fsm_v1

Parametrised successive-approximation ADC controller: next generation of the single-channel 12-bit SAR FSM, generalised in resolution and channel count, with oversampling/averaging, multi-channel scan, DAC settling delay and comparator-timeout recovery. It sits between the analog front-end mux/sample switch, the DAC and an external comparator (`fire_comp`/`comp_done` handshake). Fully synchronous to one clock.

## Interface
- `WIDTH`, 12: conversion resolution in bits (≥2).
- `CHANNELS`, 4: input mux channels (≥2); `CH_W = $clog2(CHANNELS)`, derived locally.
- `AVG_LOG2_MAX`, 3: maximum log2 of samples averaged per result.
- `SAMPLE_CYCLES`, 4: cycles `sample` is held high per sub-conversion (≥1).
- `SETTLE_CYCLES`, 2: DAC settling cycles before each comparator fire (≥0).
- `TIMEOUT`, 15: cycles waited for `comp_done` before abort (≥1).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `st_conv`  in  1  start request, sampled only in IDLE.
- `ch_sel`  in  CH_W  channel, captured at start (single mode).
- `scan_mode`  in  1  captured at start; 1 = convert channels 0..CHANNELS-1 in order.
- `avg_log2`  in  2  captured at start; samples averaged = 2^min(avg_log2, AVG_LOG2_MAX).
- `comp_in`  in  1  comparator decision; 1 = input ≥ DAC (keep trial bit).
- `comp_done`  in  1  comparator result valid, one-cycle pulse.
- `sample`  out  1  sample switch enable.
- `mux_ch`  out  CH_W  current mux channel.
- `dac_value`  out  WIDTH  SAR trial code.
- `fire_comp`  out  1  comparator trigger, one-cycle pulse.
- `result`  out  WIDTH  averaged conversion result, held until next `adc_done`.
- `result_ch`  out  CH_W  channel of `result`.
- `adc_done`  out  1  one-cycle pulse, `result`/`result_ch` valid same cycle.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on comparator timeout abort.

## Operation
- States: IDLE, SAMPLE, SETTLE, FIRE, WAIT, ACCUM, DONE.
- IDLE: on `st_conv`=1 capture `ch_sel` (≥CHANNELS → 0), `scan_mode` (scan starts at channel 0), clamped `avg_log2`; clear accumulator and sub-conversion count → SAMPLE.
- SAMPLE: `sample`=1, `dac_value`=0 for SAMPLE_CYCLES cycles; trial bit := MSB, code := 0 → SETTLE.
- SETTLE: `dac_value` = code | trial bit, held SETTLE_CYCLES cycles (0 → straight to FIRE) → FIRE.
- FIRE: `fire_comp`=1 one cycle → WAIT.
- WAIT: `comp_done` ignored in all other states. On `comp_done`: if `comp_in` keep trial bit in code; if trial bit was LSB → ACCUM, else shift trial bit right → SETTLE. After TIMEOUT cycles in WAIT without `comp_done` → IDLE, `timeout_err` pulse, scan/average aborted, `result` unchanged, no `adc_done`.
- ACCUM (1 cycle): acc += code (acc width WIDTH+AVG_LOG2_MAX, no overflow possible); if fewer than 2^avg samples → SAMPLE (fresh sample), else → DONE.
- DONE (1 cycle): `result` = acc >> avg (truncating), `result_ch` = `mux_ch`, `adc_done`=1. Scan mode and channel < CHANNELS-1: channel+1, clear acc → SAMPLE; else → IDLE.
- `st_conv` outside IDLE ignored (not queued). `mux_ch` holds last channel in IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; acc, code, counters 0. `rst` asserted mid-conversion → IDLE next edge, no `adc_done`, `result` cleared.
- Comparator latency L ≥ 1: `comp_done` sampled earliest the cycle after FIRE.
- Cycles per sub-conversion: SAMPLE_CYCLES + WIDTH·(SETTLE_CYCLES+1+L) + 1.
- Defaults, L=1, avg 0, single: acceptance edge = cycle 0; SAMPLE cycles 1–4; bits 5–52; ACCUM 53; `adc_done` cycle 54; `busy` low cycle 55; next `st_conv` accepted cycle 55.
- Scan: next channel's SAMPLE starts the cycle after DONE; `adc_done` per channel, 54 cycles apart (defaults).
- `comp_done` arriving in same cycle as timeout expiry: `comp_done` wins.

## Test plan
- Ideal comparator (L=1, comp_in = vin ≥ dac_value), single, ch 2, vin=0x5A3, avg 0 → `adc_done` at cycle 54, `result`=0x5A3, `result_ch`=2; sweep vin 0..4095 → result == vin for all codes.
- avg_log2=2, vin alternating 0x100/0x103 per sample → 4 sub-conversions, `result`=0x101; avg_log2=3 with AVG_LOG2_MAX=2 → clamps to 4 samples.
- scan_mode=1, channel inputs 0x010,0x7FF,0x800,0xFFF → four `adc_done` pulses, result_ch 0..3 with matching results, then IDLE.
- Comparator never answers → `timeout_err` pulse 15 cycles into first WAIT, `busy` low next cycle, previous `result` retained; next conversion succeeds.
- `rst` during bit 6 → all outputs 0 next cycle; `st_conv` during busy → ignored, exactly one `adc_done`.
- Stray `comp_done` during SETTLE/SAMPLE and L=5 latency → no effect, correct result, adc_done at cycle 102.
